muldiv_hilo_ctrl: RTL and testbench

- Sequences the EXE-stage multiplier and the iterative divider, and owns the architectural HI/LO registers.
- Accepts one MULT/DIV/MTHI/MTLO request per cycle from EXE and latches the operands.
- Holds EXE with a stall until the multiplier latency elapses or the divider reports complete, then commits HI/LO.
- On a pipeline flush it aborts the operation in flight and leaves HI/LO unchanged.

---
 rtl/muldiv_hilo_ctrl.sv | 173 +++++++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl
// Sequences the EXE-stage multiplier and the iterative divider and owns the
// architectural HI/LO registers. A MULT/DIV request accepted from EXE latches
// its operands, and EXE is stalled until the product is ready or the divider
// completes. HI/LO are then committed. MTHI/MTLO write HI/LO directly. A flush
// aborts whatever is in flight and leaves HI/LO untouched.
//
// Handshake: EXE presents a request with req_valid. The controller answers with
// stall. While stall=1, EXE holds the same instruction. In the cycle where
// stall=0, EXE advances on the next edge. The final mul/div cycle has stall=0
// and done=1, so EXE moves on with the same edge that writes HI/LO.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   req_valid            EXE holds a valid instruction
//   req_mult/req_div     MULT(U) / DIV(U); mult wins if both are set
//   req_unsigned         unsigned variant
//   req_mthi/req_mtlo    move-to HI / LO from src_a
//   src_a, src_b         forwarded rs / rt operands
//   flush                exception/ERET flush of EXE
//   mul_result           multiplier product {hi,lo}
//   div_complete         divider done pulse
//   div_result           divider output {remainder,quotient}
//   op_a, op_b, op_sign  latched operands and signedness for mul/div units
//   div_start            divider run, high for as long as the DIV state lasts
//   div_abort            one-cycle divider reset when a DIV is flushed
//   stall                freeze EXE
//   hi, lo               architectural HI/LO registers
//   done                 one-cycle pulse on a mul/div HI/LO commit
//   dbg_state            current FSM state (0 IDLE, 1 MUL, 2 DIV)
module muldiv_hilo_ctrl #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_mult,
    input  logic        req_div,
    input  logic        req_unsigned,
    input  logic        req_mthi,
    input  logic        req_mtlo,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic [63:0] mul_result,
    input  logic        div_complete,
    input  logic [63:0] div_result,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        op_sign,
    output logic        div_start,
    output logic        div_abort,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_e;

    localparam logic [3:0] MulLast = 4'(MUL_LAT);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] op_a_q;
    logic [31:0] op_b_q;
    logic        op_sign_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic is_idle;
    logic is_mul;
    logic is_div;
    logic req_muldiv;
    logic mul_last;

    assign is_idle    = (state_q == S_IDLE);
    assign is_mul     = (state_q == S_MUL);
    assign is_div     = (state_q == S_DIV);
    assign req_muldiv = req_valid & (req_mult | req_div);
    // The counter is 1 in the first MUL cycle, so the product is consumed
    // MUL_LAT cycles after the accept cycle.
    assign mul_last   = is_mul & (cnt_q == MulLast);

    // Stall and done have to act within the current cycle, so they are decoded
    // from the registered state. All of them are forced low during reset.
    // A flush overrides stall and done so that EXE is released and nothing
    // gets committed.
    always_comb begin
        stall     = 1'b0;
        done      = 1'b0;
        div_start = 1'b0;
        div_abort = 1'b0;
        if (!reset) begin
            div_start = is_div;
            div_abort = is_div & flush;
            if (!flush) begin
                stall = (is_idle & req_muldiv) | (is_mul & ~mul_last)
                      | (is_div & ~div_complete);
                done  = mul_last | (is_div & div_complete);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            op_a_q    <= 32'd0;
            op_b_q    <= 32'd0;
            op_sign_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else if (flush) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_muldiv) begin
                        op_a_q    <= src_a;
                        op_b_q    <= src_b;
                        op_sign_q <= ~req_unsigned;
                        if (req_mult) begin
                            state_q <= S_MUL;
                            cnt_q   <= 4'd1;
                        end else begin
                            state_q <= S_DIV;
                        end
                    end else if (req_valid) begin
                        if (req_mthi) hi_q <= src_a;
                        if (req_mtlo) lo_q <= src_a;
                    end
                end
                // Requests seen here belong to the instruction already in flight.
                S_MUL: begin
                    if (cnt_q == MulLast) begin
                        hi_q    <= mul_result[63:32];
                        lo_q    <= mul_result[31:0];
                        state_q <= S_IDLE;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_DIV: begin
                    if (div_complete) begin
                        hi_q    <= div_result[63:32];
                        lo_q    <= div_result[31:0];
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_sign   = op_sign_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Testbench for muldiv_hilo_ctrl with MUL_LAT=2.
// Inputs are driven on the falling edge. Combinational outputs are checked
// #1 later. Registered outputs are checked #1 after the rising edge.
// The multiplier model returns the product two cycles after the accept cycle.
// The divider model raises div_complete in the div_lat-th cycle of div_start.
module tb_muldiv_hilo_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_mult;
    logic        req_div;
    logic        req_unsigned;
    logic        req_mthi;
    logic        req_mtlo;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic [63:0] mul_result;
    logic        div_complete;
    logic [63:0] div_result;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_sign;
    logic        div_start;
    logic        div_abort;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    int div_lat  = 4;
    int div_cnt  = 0;

    muldiv_hilo_ctrl #(.MUL_LAT(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_mult(req_mult),
        .req_div(req_div), .req_unsigned(req_unsigned), .req_mthi(req_mthi),
        .req_mtlo(req_mtlo), .src_a(src_a), .src_b(src_b), .flush(flush),
        .mul_result(mul_result), .div_complete(div_complete),
        .div_result(div_result), .op_a(op_a), .op_b(op_b), .op_sign(op_sign),
        .div_start(div_start), .div_abort(div_abort), .stall(stall),
        .hi(hi), .lo(lo), .done(done), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- unit models ----------------
    function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic s);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'd0, a};
        eb = s ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic s);
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
        return {a % b, a / b};
    endfunction

    always @(posedge clk) mul_result <= mul_model(op_a, op_b, op_sign);

    assign div_result   = div_model(op_a, op_b, op_sign);
    assign div_complete = div_start && (div_cnt == div_lat - 1);

    always @(posedge clk) begin
        if (!div_start || div_abort || div_complete) div_cnt <= 0;
        else div_cnt <= div_cnt + 1;
    end

    // ---------------- checkers ----------------
    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic set_req(input logic v, input logic m, input logic d, input logic u,
                           input logic mh, input logic ml, input logic [31:0] a,
                           input logic [31:0] b, input logic fl);
        req_valid    = v;
        req_mult     = m;
        req_div      = d;
        req_unsigned = u;
        req_mthi     = mh;
        req_mtlo     = ml;
        src_a        = a;
        src_b        = b;
        flush        = fl;
    endtask

    task automatic clear_req();
        set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        v, m, d, u, mh, ml;
        logic [31:0] a, b;
        logic        fl;
        logic        e_stall, e_done;
        logic [31:0] e_hi, e_lo;
        logic [1:0]  e_state;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic m, input logic d, input logic u,
                                input logic mh, input logic ml, input logic [31:0] a,
                                input logic [31:0] b, input logic fl, input logic es,
                                input logic ed, input logic [31:0] eh, input logic [31:0] el,
                                input logic [1:0] est);
        vec_t r;
        r.v = v; r.m = m; r.d = d; r.u = u; r.mh = mh; r.ml = ml;
        r.a = a; r.b = b; r.fl = fl;
        r.e_stall = es; r.e_done = ed; r.e_hi = eh; r.e_lo = el; r.e_state = est;
        return r;
    endfunction

    vec_t vecs[15];

    initial begin
        int ndone;
        // Columns: v m d u mthi mtlo a b flush | stall done | hi lo state (after edge)
        vecs[0]  = mk(1,0,0,0,1,0, 32'h12345678, 0, 0, 0,0, 32'h12345678, 32'h0, 2'd0);
        vecs[1]  = mk(1,0,0,0,0,1, 32'hCAFEF00D, 0, 0, 0,0, 32'h12345678, 32'hCAFEF00D, 2'd0);
        vecs[2]  = mk(0,0,0,0,0,0, 0, 0, 0, 0,0, 32'h12345678, 32'hCAFEF00D, 2'd0);
        vecs[3]  = mk(1,1,0,0,0,0, 32'hFFFFFFFD, 5, 0, 1,0, 32'h12345678, 32'hCAFEF00D, 2'd1);
        vecs[4]  = mk(1,1,0,0,0,0, 32'hFFFFFFFD, 5, 0, 1,0, 32'h12345678, 32'hCAFEF00D, 2'd1);
        vecs[5]  = mk(1,1,0,0,0,0, 32'hFFFFFFFD, 5, 0, 0,1, 32'hFFFFFFFF, 32'hFFFFFFF1, 2'd0);
        vecs[6]  = mk(0,0,0,0,0,0, 0, 0, 0, 0,0, 32'hFFFFFFFF, 32'hFFFFFFF1, 2'd0);
        vecs[7]  = mk(1,1,0,1,0,0, 2, 3, 0, 1,0, 32'hFFFFFFFF, 32'hFFFFFFF1, 2'd1);
        vecs[8]  = mk(1,1,0,1,0,0, 2, 3, 0, 1,0, 32'hFFFFFFFF, 32'hFFFFFFF1, 2'd1);
        vecs[9]  = mk(1,1,0,1,0,0, 2, 3, 1, 0,0, 32'hFFFFFFFF, 32'hFFFFFFF1, 2'd0);
        vecs[10] = mk(1,1,0,1,0,0, 2, 3, 1, 0,0, 32'hFFFFFFFF, 32'hFFFFFFF1, 2'd0);
        vecs[11] = mk(1,0,0,0,1,0, 32'h0BADF00D, 0, 1, 0,0, 32'hFFFFFFFF, 32'hFFFFFFF1, 2'd0);
        vecs[12] = mk(1,1,0,1,0,0, 2, 3, 0, 1,0, 32'hFFFFFFFF, 32'hFFFFFFF1, 2'd1);
        vecs[13] = mk(1,0,0,0,0,1, 32'hDEADBEEF, 0, 0, 1,0, 32'hFFFFFFFF, 32'hFFFFFFF1, 2'd1);
        vecs[14] = mk(0,0,0,0,0,0, 0, 0, 0, 0,1, 32'h0, 32'h6, 2'd0);

        // ---------------- reset ----------------
        reset = 1'b1;
        clear_req();
        @(negedge clk);
        set_req(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h11, 32'h22, 1'b0);
        #1;
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_div_start", div_start, 1'b0);
        chk1("rst_div_abort", div_abort, 1'b0);
        @(posedge clk); #1;
        chk32("rst_hi", hi, 32'h0);
        chk32("rst_lo", lo, 32'h0);
        chk32("rst_op_a", op_a, 32'h0);
        chk32("rst_op_b", op_b, 32'h0);
        chk1("rst_op_sign", op_sign, 1'b0);
        chk32("rst_state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        clear_req();

        // ---------------- table vectors ----------------
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            set_req(vecs[i].v, vecs[i].m, vecs[i].d, vecs[i].u, vecs[i].mh, vecs[i].ml,
                    vecs[i].a, vecs[i].b, vecs[i].fl);
            #1;
            chk1($sformatf("v%0d_stall", i), stall, vecs[i].e_stall);
            chk1($sformatf("v%0d_done", i), done, vecs[i].e_done);
            @(posedge clk); #1;
            chk32($sformatf("v%0d_hi", i), hi, vecs[i].e_hi);
            chk32($sformatf("v%0d_lo", i), lo, vecs[i].e_lo);
            chk32($sformatf("v%0d_state", i), {30'd0, dbg_state}, {30'd0, vecs[i].e_state});
        end

        // ---------------- DIVU 100/7, complete after 33 cycles ----------------
        div_lat = 33;
        @(negedge clk);
        set_req(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd100, 32'd7, 1'b0);
        #1;
        chk1("divu_acc_stall", stall, 1'b1);
        @(posedge clk); #1;
        chk32("divu_acc_state", {30'd0, dbg_state}, 32'd2);
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk); #1;
            chk1($sformatf("divu_c%0d_start", k), div_start, 1'b1);
            chk1($sformatf("divu_c%0d_stall", k), stall, k < 33);
            chk1($sformatf("divu_c%0d_done", k), done, k == 33);
            chk1($sformatf("divu_c%0d_abort", k), div_abort, 1'b0);
            @(posedge clk); #1;
            if (k < 33) chk32($sformatf("divu_c%0d_hi_hold", k), hi, 32'h0);
        end
        chk32("divu_hi", hi, 32'd2);
        chk32("divu_lo", lo, 32'd14);
        chk1("divu_op_sign", op_sign, 1'b0);
        chk32("divu_state", {30'd0, dbg_state}, 32'd0);

        // ---------------- flush 5 cycles into a DIV ----------------
        @(negedge clk);
        set_req(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFF9C, 32'd7, 1'b0);
        #1;
        chk1("dflush_acc_stall", stall, 1'b1);
        @(posedge clk); #1;
        chk32("dflush_acc_state", {30'd0, dbg_state}, 32'd2);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            flush = (k == 5);
            #1;
            chk1($sformatf("dflush_c%0d_abort", k), div_abort, k == 5);
            chk1($sformatf("dflush_c%0d_stall", k), stall, k != 5);
            chk1($sformatf("dflush_c%0d_done", k), done, 1'b0);
            @(posedge clk); #1;
        end
        chk32("dflush_state", {30'd0, dbg_state}, 32'd0);
        chk32("dflush_hi", hi, 32'd2);
        chk32("dflush_lo", lo, 32'd14);
        @(negedge clk);
        set_req(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd7, 32'd6, 1'b0);
        #1;
        chk1("dflush_mul_acc_stall", stall, 1'b1);
        chk1("dflush_mul_acc_abort", div_abort, 1'b0);
        @(posedge clk); #1;
        chk32("dflush_mul_state", {30'd0, dbg_state}, 32'd1);
        chk1("dflush_mul_op_sign", op_sign, 1'b1);
        chk32("dflush_mul_op_a", op_a, 32'd7);
        @(negedge clk);
        clear_req();
        #1;
        chk1("dflush_mul_c1_stall", stall, 1'b1);
        @(negedge clk); #1;
        chk1("dflush_mul_c2_stall", stall, 1'b0);
        chk1("dflush_mul_c2_done", done, 1'b1);
        @(posedge clk); #1;
        chk32("dflush_mul_hi", hi, 32'd0);
        chk32("dflush_mul_lo", lo, 32'd42);

        // ---------------- back-to-back MULT then DIVU ----------------
        div_lat = 3;
        ndone = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            set_req(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4, 1'b0);
            #1;
            chk1($sformatf("b2b_m%0d_stall", c), stall, c != 2);
            if (done) ndone++;
            @(posedge clk); #1;
        end
        chk32("b2b_mul_hi", hi, 32'd0);
        chk32("b2b_mul_lo", lo, 32'd12);
        chk32("b2b_mul_state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        set_req(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd9, 32'd2, 1'b0);
        #1;
        chk1("b2b_div_acc_stall", stall, 1'b1);
        if (done) ndone++;
        @(posedge clk); #1;
        chk32("b2b_mul_done_count", ndone, 32'd1);
        chk32("b2b_div_state", {30'd0, dbg_state}, 32'd2);
        @(negedge clk);
        clear_req();
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            chk1($sformatf("b2b_d%0d_done", k), done, k == 3);
            @(posedge clk); #1;
        end
        chk32("b2b_div_hi", hi, 32'd1);
        chk32("b2b_div_lo", lo, 32'd4);

        // ---------------- reset in the middle of a DIV ----------------
        div_lat = 33;
        @(negedge clk);
        set_req(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd9, 32'd2, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        clear_req();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk1("midrst_div_start", div_start, 1'b0);
        chk1("midrst_div_abort", div_abort, 1'b0);
        chk1("midrst_stall", stall, 1'b0);
        @(posedge clk); #1;
        chk32("midrst_state", {30'd0, dbg_state}, 32'd0);
        chk32("midrst_hi", hi, 32'd0);
        chk32("midrst_lo", lo, 32'd0);
        chk32("midrst_op_a", op_a, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
